// File: rtl/hough_transform_coordinate_pkg.sv
// Shared Hough-vote parameters, bus types and trig table generator.
// The table functions are evaluated only at elaboration time.
package hough_transform_coordinate_pkg;

  localparam int COORD_W     = 10;
  localparam int THETA_STEPS = 180;
  localparam int FRAC        = 10;
  localparam int TRIG_W      = 12;
  localparam int RHO_W       = 12;
  localparam int THETA_W     = 8;
  localparam int PROD_W      = COORD_W + TRIG_W + 2;
  localparam int HALF        = THETA_STEPS / 2;

  typedef logic        [COORD_W-1:0] coord_t;
  typedef logic signed [TRIG_W-1:0]  trig_t;
  typedef logic signed [RHO_W-1:0]   rho_t;
  typedef logic        [THETA_W-1:0] theta_t;

  typedef struct packed {
    trig_t c;
    trig_t s;
  } trig_pair_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  // pi in Q30; Taylor series keeps ~1e-9 error,
  // far below the 2^-FRAC rounding step
  localparam int     FX    = 30;
  localparam longint PI_FX = 64'sd3373259426;

  // round(sin(d*pi/THETA_STEPS) * 2^FRAC), d in 0..HALF
  function automatic longint quarter_sin(int d);
    longint a;
    longint a2;
    longint term;
    longint sum;
    a    = (longint'(d) * PI_FX) / longint'(THETA_STEPS);
    a2   = (a * a) >>> FX;
    term = a;
    sum  = a;
    for (int n = 1; n <= 12; n++) begin
      term = -((term * a2) >>> FX)
             / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return (sum + (longint'(1) <<< (FX - FRAC - 1)))
           >>> (FX - FRAC);
  endfunction

  // Folding onto the first quadrant makes the
  // rounding symmetric, i.e. half away from zero.
  function automatic trig_t lut_sin(int k);
    int d;
    d = (k <= HALF) ? k : THETA_STEPS - k;
    return trig_t'(quarter_sin(d));
  endfunction

  function automatic trig_t lut_cos(int k);
    if (k <= HALF)
      return trig_t'(quarter_sin(HALF - k));
    return -trig_t'(quarter_sin(k - HALF));
  endfunction

endpackage

// File: rtl/hough_trig_lut.sv
// Synchronous cos/sin ROM, one-cycle read latency.
// Ports: clk, rst_n, k (angle index), trig ({cos_k, sin_k}).
module hough_trig_lut
  import hough_transform_coordinate_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  theta_t     k,
  output trig_pair_t trig
);

  trig_pair_t rom [THETA_STEPS];

  for (genvar i = 0; i < THETA_STEPS; i++) begin : g_rom
    localparam trig_t C = lut_cos(i);
    localparam trig_t S = lut_sin(i);
    assign rom[i] = '{c: C, s: S};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trig <= '0;
    else        trig <= rom[k];
  end

endmodule

// File: rtl/hough_transform_coordinate.sv
// Sweeps theta for one edge pixel and emits one (theta, rho) vote/cycle.
// Ports: clk, rst_n, start, x, y -> busy, vote_valid, theta_idx, rho, done.
module hough_transform_coordinate
  import hough_transform_coordinate_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [COORD_W-1:0]      x,
  input  logic [COORD_W-1:0]      y,
  output logic                    busy,
  output logic                    vote_valid,
  output logic [THETA_W-1:0]      theta_idx,
  output logic signed [RHO_W-1:0] rho,
  output logic                    done
);

  localparam theta_t LAST = theta_t'(THETA_STEPS - 1);
  localparam logic signed [PROD_W-1:0] RND =
    PROD_W'(1) <<< (FRAC - 1);

  state_t     state;
  state_t     state_nxt;
  theta_t     k;
  theta_t     k1;
  coord_t     xl;
  coord_t     yl;
  logic       v1;
  trig_pair_t trig;
  trig_t      c_k;
  trig_t      s_k;
  logic       accept;
  logic       drained;

  logic signed [PROD_W-1:0] xs;
  logic signed [PROD_W-1:0] ys;
  logic signed [PROD_W-1:0] cs;
  logic signed [PROD_W-1:0] ss;
  logic signed [PROD_W-1:0] acc;
  rho_t                     rho_nxt;

  assign accept  = start && (state == IDLE);
  assign drained = vote_valid && !v1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)   state_nxt = RUN;
      RUN:     if (k == LAST) state_nxt = DRAIN;
      DRAIN:   if (drained) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  hough_trig_lut u_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .k     (k),
    .trig  (trig)
  );

  assign c_k = trig.c;
  assign s_k = trig.s;
  assign xs  = signed'(PROD_W'(xl));
  assign ys  = signed'(PROD_W'(yl));
  assign cs  = PROD_W'(c_k);
  assign ss  = PROD_W'(s_k);
  assign acc = xs * cs + ys * ss + RND;
  // floor after the half-LSB bias gives round half up
  assign rho_nxt = RHO_W'(acc >>> FRAC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xl         <= '0;
      yl         <= '0;
      k          <= '0;
      k1         <= '0;
      v1         <= 1'b0;
      vote_valid <= 1'b0;
      theta_idx  <= '0;
      rho        <= '0;
      done       <= 1'b0;
    end else begin
      if (accept) begin
        xl <= x;
        yl <= y;
        k  <= '0;
      end else if (state == RUN && k != LAST) begin
        k <= k + 1'b1;
      end
      v1         <= (state == RUN);
      k1         <= k;
      vote_valid <= v1;
      if (v1) begin
        theta_idx <= k1;
        rho       <= rho_nxt;
      end
      done <= (state == DRAIN) && drained;
    end
  end

endmodule

// File: tb/tb_hough_transform_coordinate.sv
// Randomized self-checking bench for hough_transform_coordinate.
// Reference computes votes from real-valued trig with explicit rounding.
module tb_hough_transform_coordinate;

  localparam int STEPS = 180;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [9:0]        x;
  logic [9:0]        y;
  logic              busy;
  logic              vote_valid;
  logic [7:0]        theta_idx;
  logic signed [11:0] rho;
  logic              done;

  int checks = 0;
  int failures = 0;

  int v_theta [STEPS];
  int v_rho   [STEPS];
  int v_m     [STEPS];
  int nv, ndone, done_m, done_busy, done_vv, busy0, busy181;

  always #5 clk = ~clk;

  hough_transform_coordinate dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .x          (x),
    .y          (y),
    .busy       (busy),
    .vote_valid (vote_valid),
    .theta_idx  (theta_idx),
    .rho        (rho),
    .done       (done)
  );

  function automatic int trig_ref(int k, bit is_cos);
    real a, r;
    a = 3.14159265358979323846 * k / 180.0;
    r = (is_cos ? $cos(a) : $sin(a)) * 1024.0;
    if (r >= 0.0) return int'($floor(r + 0.5));
    return -int'($floor(-r + 0.5));
  endfunction

  function automatic int rho_ref(int xv, int yv, int k);
    int v;
    v = xv * trig_ref(k, 1) + yv * trig_ref(k, 0) + 512;
    if (v >= 0) return v / 1024;
    return -((-v + 1023) / 1024);
  endfunction

  // m = number of rising edges after the start edge E0
  task automatic capture(input int xv, input int yv,
                         input bit restart,
                         input int ax, input int ay);
    nv = 0; ndone = 0; done_m = -1;
    done_busy = -1; done_vv = -1; busy0 = -1; busy181 = -1;
    @(negedge clk);
    start = 1'b1; x = 10'(xv); y = 10'(yv);
    for (int m = 0; m < 200; m++) begin
      @(negedge clk);
      start = 1'b0;
      if (restart && m == 50) begin
        start = 1'b1; x = 10'(ax); y = 10'(ay);
      end
      if (m == 0) busy0 = busy;
      if (m == 181) busy181 = busy;
      if (vote_valid) begin
        if (nv < STEPS) begin
          v_theta[nv] = theta_idx;
          v_rho[nv]   = rho;
          v_m[nv]     = m;
        end
        nv++;
      end
      if (done) begin
        ndone++;
        if (done_m < 0) begin
          done_m = m; done_busy = busy; done_vv = vote_valid;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; x = '0; y = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || vote_valid !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl busy=%b vv=%b done=%b want 000",
               busy, vote_valid, done);
    end
    checks++;
    if (theta_idx !== 8'd0 || rho !== 12'sd0) begin
      failures++;
      $display("FAIL reset_data theta=%0d rho=%0d want 0 0",
               theta_idx, rho);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sweep(input string name, input int xv, input int yv);
    int lim;
    capture(xv, yv, 1'b0, 0, 0);
    checks++;
    if (nv !== STEPS) begin
      failures++;
      $display("FAIL %s vote_count got=%0d want=%0d", name, nv, STEPS);
    end
    lim = (nv < STEPS) ? nv : STEPS;
    for (int k = 0; k < lim; k++) begin
      checks++;
      if (v_theta[k] !== k || v_m[k] !== k + 2 ||
          v_rho[k] !== rho_ref(xv, yv, k)) begin
        failures++;
        $display("FAIL %s vote%0d theta=%0d m=%0d rho=%0d want %0d %0d %0d",
                 name, k, v_theta[k], v_m[k], v_rho[k],
                 k, k + 2, rho_ref(xv, yv, k));
      end
    end
    checks++;
    if (ndone !== 1 || done_m !== 182) begin
      failures++;
      $display("FAIL %s done count=%0d at=%0d want 1 at 182",
               name, ndone, done_m);
    end
    checks++;
    if (done_busy !== 0 || done_vv !== 0 || busy0 !== 1 || busy181 !== 1) begin
      failures++;
      $display("FAIL %s busy_window at_done=%0d vv=%0d b0=%0d b181=%0d want 0 0 1 1",
               name, done_busy, done_vv, busy0, busy181);
    end
  endtask

  task automatic test_zero();
    test_sweep("zero", 0, 0);
    for (int k = 0; k < STEPS; k++) begin
      checks++;
      if (v_rho[k] !== 0) begin
        failures++;
        $display("FAIL zero_rho k=%0d got=%0d want=0", k, v_rho[k]);
      end
    end
  endtask

  task automatic test_axis_x();
    int ks [4] = '{0, 45, 90, 179};
    int ex [4] = '{100, 71, 0, -100};
    test_sweep("axis_x", 100, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (v_rho[ks[i]] !== ex[i]) begin
        failures++;
        $display("FAIL axis_x k=%0d got=%0d want=%0d",
                 ks[i], v_rho[ks[i]], ex[i]);
      end
    end
  endtask

  task automatic test_axis_y();
    int ks [3] = '{0, 90, 135};
    int ex [3] = '{0, 200, 141};
    test_sweep("axis_y", 0, 200);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (v_rho[ks[i]] !== ex[i]) begin
        failures++;
        $display("FAIL axis_y k=%0d got=%0d want=%0d",
                 ks[i], v_rho[ks[i]], ex[i]);
      end
    end
  endtask

  task automatic test_corner();
    int worst;
    test_sweep("corner", 1023, 767);
    checks++;
    if (v_rho[0] !== 1023 || v_rho[90] !== 767) begin
      failures++;
      $display("FAIL corner_axes got=%0d,%0d want 1023,767",
               v_rho[0], v_rho[90]);
    end
    worst = 0;
    for (int k = 0; k < STEPS; k++)
      if (v_rho[k] > worst || -v_rho[k] > worst)
        worst = (v_rho[k] < 0) ? -v_rho[k] : v_rho[k];
    checks++;
    if (worst > 1279 || worst < 1270) begin
      failures++;
      $display("FAIL corner_range max_abs=%0d want 1270..1279", worst);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++)
      test_sweep("random", int'($urandom_range(1023)),
                 int'($urandom_range(767)));
  endtask

  task automatic test_start_ignored();
    int xv, yv, bad;
    xv = 321; yv = 654;
    capture(xv, yv, 1'b1, 777, 5);
    bad = 0;
    for (int k = 0; k < STEPS; k++)
      if (v_rho[k] !== rho_ref(xv, yv, k)) bad++;
    checks++;
    if (nv !== STEPS || bad !== 0) begin
      failures++;
      $display("FAIL start_ignored votes=%0d bad_rho=%0d want 180 0", nv, bad);
    end
    checks++;
    if (ndone !== 1 || done_m !== 182) begin
      failures++;
      $display("FAIL start_ignored_done count=%0d at=%0d want 1 at 182",
               ndone, done_m);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    int m2;
    @(negedge clk);
    start = 1'b1; x = 10'd50; y = 10'd60;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 250 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL b2b_first_done got=0 want=1");
    end
    checks++;
    if (vote_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done_cycle vv=%b busy=%b want 0 0", vote_valid, busy);
    end
    start = 1'b1; x = 10'd900; y = 10'd33;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept busy=%b want 1", busy);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (vote_valid !== 1'b1 || theta_idx !== 8'd0 ||
        rho !== 12'(rho_ref(900, 33, 0))) begin
      failures++;
      $display("FAIL b2b_first_vote vv=%b theta=%0d rho=%0d want 1 0 %0d",
               vote_valid, theta_idx, rho, rho_ref(900, 33, 0));
    end
    m2 = 2; seen = 0;
    while (m2 < 300 && !seen) begin
      @(negedge clk);
      m2++;
      if (done) seen = 1;
    end
    checks++;
    if (!seen || m2 !== 182) begin
      failures++;
      $display("FAIL b2b_second_done seen=%0d at=%0d want 1 at 182", seen, m2);
    end
  endtask

  task automatic test_reset_mid();
    int nd;
    @(negedge clk);
    start = 1'b1; x = 10'd300; y = 10'd400;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || vote_valid !== 1'b0 || done !== 1'b0 ||
        theta_idx !== 8'd0 || rho !== 12'sd0) begin
      failures++;
      $display("FAIL reset_mid busy=%b vv=%b done=%b theta=%0d rho=%0d want all 0",
               busy, vote_valid, done, theta_idx, rho);
    end
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (200) begin
      @(negedge clk);
      if (done || vote_valid) nd++;
    end
    checks++;
    if (nd !== 0) begin
      failures++;
      $display("FAIL reset_mid_quiet activity=%0d want=0", nd);
    end
    test_sweep("after_reset", int'($urandom_range(1023)),
               int'($urandom_range(767)));
  endtask

  initial begin
    test_reset();
    test_zero();
    test_axis_x();
    test_axis_y();
    test_corner();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hough_transform_coordinate.md
Name: hough_transform_coordinate

Overview:
Computes the Hough-transform votes for one edge-pixel coordinate. On a start pulse it latches (x, y) and sweeps theta over THETA_STEPS angles from 0 to pi. For each angle it emits one vote (theta_idx, rho = x·cos + y·sin), one vote per cycle. Sits between the edge-detector pixel stream and the accumulator RAM controller, which increments the accumulator at the address (theta_idx, rho). done pulses once the sweep completes.

Parameters:
COORD_W, 10, width of unsigned x/y coordinates (frame up to 1023x767)
THETA_STEPS, 180, number of angles; step = pi/THETA_STEPS
FRAC, 10, fractional bits of trig LUT entries
TRIG_W, 12, signed width of LUT entries (range -1024..1024)
RHO_W, 12, signed width of rho output

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; accepted only when busy=0
x  in  COORD_W  pixel column, sampled when start is accepted
y  in  COORD_W  pixel row, sampled when start is accepted
busy  out  1  sweep in progress
vote_valid  out  1  theta_idx/rho valid this cycle
theta_idx  out  8  angle index 0..THETA_STEPS-1
rho  out  RHO_W  signed rho for theta_idx
done  out  1  one-cycle pulse at end of sweep

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; busy, vote_valid, done = 0; theta_idx, rho = 0; latched x/y = 0. Reset mid-sweep aborts the sweep; no done pulse is produced.
- States:
  - IDLE: start=1 moves to RUN at edge E0 and latches x/y.
  - RUN: the angle counter k steps 0..THETA_STEPS-1, one per cycle.
  - DRAIN: the pipeline empties, then the block returns to IDLE.
- Pipeline:
  - Stage 1: registered LUT read of cos_k and sin_k.
  - Stage 2: registered product-sum, rho = (x·cos_k + y·sin_k + 2^(FRAC-1)) >>> FRAC. This is an arithmetic shift, i.e. round half up. Intermediate width is at least COORD_W+TRIG_W+2 signed bits.
- Timing: the vote for k is valid after edge E0+2+k. vote_valid stays high for exactly THETA_STEPS consecutive cycles with no gaps.
- done: high for one cycle after edge E0+2+THETA_STEPS; vote_valid is 0 in that cycle. busy falls in the same cycle that done rises.
- busy: high from after E0 until done rises.
- start handling:
  - start while busy=1 is ignored and does not relatch x/y.
  - start in the done cycle is accepted, since busy=0 then.
- LUT contents:
  - cos_k = round(cos(k·pi/THETA_STEPS)·2^FRAC), round half away from zero.
  - sin_k likewise.
  - Values are exact integers; k=0 gives cos 1024, sin 0; k=90 gives cos 0, sin 1024.
- rho range: |rho| ≤ sqrt(1023²+767²) ≈ 1279, which fits in RHO_W=12 without overflow. Negative rho is valid output.
- theta_idx and rho hold their last values when vote_valid=0.

Decomposition:
- Shared package: COORD_W, THETA_STEPS, FRAC, TRIG_W, RHO_W, and the rho/theta typedefs used by the accumulator.
- One sub-module, hough_trig_lut: synchronous ROM mapping k to {cos_k, sin_k}, with one-cycle read latency.

Test Plan:
- Zero point: x=0, y=0, start pulse.
  - Required: 180 votes, all with rho=0 and theta_idx 0..179 in order.
  - done asserts exactly once, 182 cycles after the start edge; busy drops at the same time.
- x=100, y=0, required votes:
  - theta_idx 0: rho=100.
  - theta_idx 45: rho=71 (cos=724).
  - theta_idx 90: rho=0.
  - theta_idx 179: rho=-100 (cos=-1024).
- x=0, y=200, required votes:
  - theta_idx 0: rho=0.
  - theta_idx 90: rho=200.
  - theta_idx 135: rho=141 (sin=724).
- Corner x=1023, y=767:
  - theta_idx 0: rho=1023.
  - theta_idx 90: rho=767.
  - Required: no overflow anywhere; every rho lies within ±1279.
- start re-asserted at cycle 50 of a sweep with different x/y: ignored. The sweep completes with the original rho values, and done occurs at the original cycle.
- rst_n pulsed low mid-sweep: outputs go to 0 immediately and no done pulse appears. A new start after reset produces a full 180-vote sweep.
